pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Replaces the separate control-hazard and forwarding units with one block that keeps its own scoreboard of in-flight instructions for EX, MEM and WB.
- Generates load-use stalls, branch/jump flushes for a configurable resolve stage, and registered ALU operand-forwarding selects.

Parameters:
REG_AW, 5, register-address width (5 = 32 GPRs; 6 supported).
BR_STAGE, 3, stage in which branch/jump is resolved: 2 = EX, 3 = MEM; other values illegal (elaboration error).
STAT_W, 32, width of statistics counters (optional feature only).

Ports:
clk  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high reset.
id_valid  in  1  ID holds a real instruction.
id_rs  in  REG_AW  source A address.
id_rt  in  REG_AW  source B address.
id_use_rs  in  1  instruction reads rs.
id_use_rt  in  1  instruction reads rt (register operand, not immediate).
id_regwr  in  1  instruction writes a register.
id_rd  in  REG_AW  final destination (after RegDst mux).
id_is_load  in  1  instruction is a load.
br_taken  in  1  redirect request from stage BR_STAGE.
keep_pc  out  1  hold PC.
keep_if_id  out  1  hold IF/ID register.
flush_if_id  out  1  clear IF/ID register to NOP.
flush_id_ex  out  1  load bubble into ID/EX.
flush_ex_mem  out  1  load bubble into EX/MEM; tied 0 when BR_STAGE=2.
fwd_a_sel  out  2  EX operand A select: 0 regfile, 1 MEM-stage ALU/shift result, 2 WB result.
fwd_b_sel  out  2  EX operand B select, same encoding.
stat_stall  out  STAT_W  load-use stall count (optional feature only).
stat_flush  out  STAT_W  taken-redirect count (optional feature only).

Behaviour:
- Scoreboard holds one entry per stage: EX, MEM, WB. Each entry is {valid, regwr, rd, is_load}.
- Every cycle WB <= MEM.
- MEM <= EX, except it becomes a bubble when flush_ex_mem is high.
- EX <= ID fields (valid = id_valid), except it becomes a bubble when stall or flush_id_ex is high.
- Reset: all entries invalid; fwd_a_sel/fwd_b_sel = 0; all stall/flush outputs are 0 combinationally as a result; counters = 0.
- Hazard match(s, r): entry s is valid, has regwr, rd == r, and r != 0. Register 0 never matches, never stalls, never forwards.
- Load-use stall: stall = id_valid && ((id_use_rs && match(EX, id_rs)) || (id_use_rt && match(EX, id_rt))) && EX.is_load.
  - keep_pc = keep_if_id = flush_id_ex = stall. Lasts exactly 1 cycle per hazard.
- Redirect: take = br_taken && entry(BR_STAGE).valid. br_taken on a bubble is ignored.
  - take -> flush_if_id = 1, flush_id_ex = 1, flush_ex_mem = (BR_STAGE==3).
  - keep_pc = keep_if_id = 0.
- Simultaneous take and stall: take wins, because the stalled instruction is younger and gets squashed.
- Stall and flush outputs are combinational, from current scoreboard state and ID inputs.
- Forwarding is evaluated in ID against pre-advance entries and registered into EX:
  - An EX match becomes sel 1 next cycle (MEM source). A MEM match becomes sel 2 (WB source).
  - If both match, EX wins (newer).
  - When ID->EX is stalled or flushed, the registered selects are 0.
- A load matching the EX entry never yields sel 1, because the stall covers it. After the stall the load sits in MEM, giving sel 2.
- A match in WB at ID time is not forwarded. The register file is write-first.
- Latency: stall/flush 0 cycles; forward selects 1 cycle (valid during the consumer's EX cycle).

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined:
  - stat_stall increments on each cycle with stall && !take.
  - stat_flush increments on each take.
  - Both saturate at all-ones and clear on Reset.
- Undefined: counters are not instantiated; stat_* are driven 0.

Decomposition:
- Shared package pipe_pkg: fwd-select encoding constants (FWD_REG=0, FWD_MEM=1, FWD_WB=2), stage index constants (ST_EX=2, ST_MEM=3, ST_WB=4), scoreboard entry struct typedef.
- One natural sub-module, haz_scoreboard: the 3-entry shift with bubble insertion and the match function. Top level holds stall/flush/forward logic and the counters.

Test Plan:
- Reset asserted mid-run with valid entries in flight -> next cycle all entries invalid, fwd sels 0, no stall even if ID presents a would-be hazard.
- lw $2 in EX, ID add $3,$2,$4 -> stall=1 for one cycle. Next cycle stall=0, and in the following EX cycle fwd_a_sel=2.
- add $5 then sub $6,$5,$5 back-to-back -> no stall; fwd_a_sel=1, fwd_b_sel=1. With $0 as destination -> both 0.
- Two writers of $7 in EX and MEM, consumer in ID -> fwd sel 1 (newest wins).
- BR_STAGE=3, br_taken with valid MEM entry while a load-use stall is present -> flush_if_id, flush_id_ex, flush_ex_mem = 1; keep_pc = 0. With HAZ_STATS_EN: stat_flush +1, stat_stall unchanged.
- br_taken asserted with a bubble in stage BR_STAGE -> no flush. BR_STAGE=2 -> flush_ex_mem stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forward-select codes, stage indices
// and the per-stage scoreboard entry.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // rd is sized for the widest supported register file; narrower addresses zero-extend
  localparam int RD_MAX_W = 6;

  typedef struct packed {
    logic                valid;
    logic                regwr;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage instruction fields and redirect request in, stall/flush/forward controls out.
// master = pipeline datapath, slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int STAT_W = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_regwr;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              br_taken;
  logic              keep_pc;
  logic              keep_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [STAT_W-1:0] stat_stall;
  logic [STAT_W-1:0] stat_flush;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwr, id_rd, id_is_load, br_taken,
    input  keep_pc, keep_if_id, flush_if_id, flush_id_ex, flush_ex_mem,
    input  fwd_a_sel, fwd_b_sel, stat_stall, stat_flush
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwr, id_rd, id_is_load, br_taken,
    output keep_pc, keep_if_id, flush_if_id, flush_id_ex, flush_ex_mem,
    output fwd_a_sel, fwd_b_sel, stat_stall, stat_flush
  );
endinterface

// File: rtl/pipe_hazard_unit_scoreboard.sv
// Three-entry EX/MEM/WB shadow of in-flight instructions with bubble insertion.
// Match outputs are combinational from the current (pre-advance) entries.
module haz_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  sb_entry_t         i_id_ent,
  input  logic              i_bubble_ex,
  input  logic              i_bubble_mem,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  output logic              o_ex_rs,
  output logic              o_ex_rt,
  output logic              o_mem_rs,
  output logic              o_mem_rt,
  output logic              o_ex_load,
  output logic              o_br_valid
);

  sb_entry_t r_sb [ST_EX:ST_WB];

  function automatic logic f_match(sb_entry_t e, logic [REG_AW-1:0] r);
    return e.valid && e.regwr && (e.rd == RD_MAX_W'(r)) && (r != '0);
  endfunction

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_sb[ST_EX]  <= SB_BUBBLE;
      r_sb[ST_MEM] <= SB_BUBBLE;
      r_sb[ST_WB]  <= SB_BUBBLE;
    end else begin
      r_sb[ST_WB]  <= r_sb[ST_MEM];
      r_sb[ST_MEM] <= i_bubble_mem ? SB_BUBBLE : r_sb[ST_EX];
      r_sb[ST_EX]  <= i_bubble_ex  ? SB_BUBBLE : i_id_ent;
    end
  end

  assign o_ex_rs    = f_match(r_sb[ST_EX],  i_rs);
  assign o_ex_rt    = f_match(r_sb[ST_EX],  i_rt);
  assign o_mem_rs   = f_match(r_sb[ST_MEM], i_rs);
  assign o_mem_rt   = f_match(r_sb[ST_MEM], i_rt);
  assign o_ex_load  = r_sb[ST_EX].is_load;
  assign o_br_valid = r_sb[BR_STAGE].valid;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, redirect flush (combinational) and ALU forward selects (1-cycle registered).
// Optional saturating stall/flush counters enabled by HAZ_STATS_EN.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 3,
  parameter int STAT_W   = 32
) (
  input logic               clk,
  input logic               Reset,
  pipe_hazard_unit_if.slave hz
);

  if (BR_STAGE != ST_EX && BR_STAGE != ST_MEM) begin : g_bad_br
    $error("pipe_hazard_unit: BR_STAGE must be 2 (EX) or 3 (MEM)");
  end
  if (REG_AW < 1 || REG_AW > RD_MAX_W) begin : g_bad_aw
    $error("pipe_hazard_unit: REG_AW out of range");
  end
  if (STAT_W < 1) begin : g_bad_sw
    $error("pipe_hazard_unit: STAT_W must be positive");
  end

  localparam bit BR_IN_MEM = (BR_STAGE == ST_MEM);

  sb_entry_t  w_id_ent;
  logic       w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_ex_load, w_br_valid;
  logic       w_stall, w_take, w_flush_id_ex, w_flush_ex_mem;
  logic [1:0] r_fwd_a, r_fwd_b;

  assign w_id_ent = '{valid: hz.id_valid, regwr: hz.id_regwr,
                      rd: RD_MAX_W'(hz.id_rd), is_load: hz.id_is_load};

  haz_scoreboard #(.REG_AW(REG_AW), .BR_STAGE(BR_STAGE)) u_sb (
    .clk          (clk),
    .Reset        (Reset),
    .i_id_ent     (w_id_ent),
    .i_bubble_ex  (w_flush_id_ex),
    .i_bubble_mem (w_flush_ex_mem),
    .i_rs         (hz.id_rs),
    .i_rt         (hz.id_rt),
    .o_ex_rs      (w_ex_rs),
    .o_ex_rt      (w_ex_rt),
    .o_mem_rs     (w_mem_rs),
    .o_mem_rt     (w_mem_rt),
    .o_ex_load    (w_ex_load),
    .o_br_valid   (w_br_valid)
  );

  assign w_stall = hz.id_valid && w_ex_load &&
                   ((hz.id_use_rs && w_ex_rs) || (hz.id_use_rt && w_ex_rt));
  assign w_take  = hz.br_taken && w_br_valid;

  // A taken redirect squashes the stalled instruction, so it overrides the hold.
  assign w_flush_id_ex   = w_take || w_stall;
  assign w_flush_ex_mem  = BR_IN_MEM && w_take;
  assign hz.keep_pc      = w_stall && !w_take;
  assign hz.keep_if_id   = w_stall && !w_take;
  assign hz.flush_if_id  = w_take;
  assign hz.flush_id_ex  = w_flush_id_ex;
  assign hz.flush_ex_mem = w_flush_ex_mem;

  // Selects are gated by operand use so a load in EX can only ever surface as FWD_WB.
  function automatic logic [1:0] f_sel(logic use_op, logic ex_hit, logic mem_hit);
    if (!use_op) return FWD_REG;
    if (ex_hit)  return FWD_MEM;
    if (mem_hit) return FWD_WB;
    return FWD_REG;
  endfunction

  always_ff @(posedge clk) begin
    if (Reset || w_flush_id_ex) begin
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_fwd_a <= f_sel(hz.id_valid && hz.id_use_rs, w_ex_rs, w_mem_rs);
      r_fwd_b <= f_sel(hz.id_valid && hz.id_use_rt, w_ex_rt, w_mem_rt);
    end
  end

  assign hz.fwd_a_sel = r_fwd_a;
  assign hz.fwd_b_sel = r_fwd_b;

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] r_stat_stall, r_stat_flush;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_stat_stall <= '0;
      r_stat_flush <= '0;
    end else begin
      if (w_stall && !w_take && r_stat_stall != '1) r_stat_stall <= r_stat_stall + STAT_W'(1);
      if (w_take && r_stat_flush != '1)             r_stat_flush <= r_stat_flush + STAT_W'(1);
    end
  end

  assign hz.stat_stall = r_stat_stall;
  assign hz.stat_flush = r_stat_flush;
`else
  assign hz.stat_stall = '0;
  assign hz.stat_flush = '0;
`endif

endmodule
